// File: rtl/rc5_pkg.sv
// Shared RC5 definitions used by the transmitter and receiver.
// Frame layout, MSB first: start, field, control, address[4:0], command[5:0].
package rc5_pkg;

  localparam int unsigned RC5_FRAME_BITS = 14;
  localparam int unsigned RC5_HALF_BITS  = 2 * RC5_FRAME_BITS;

  // Bit positions inside the 14-bit frame.
  localparam int unsigned RC5_START    = 13;
  localparam int unsigned RC5_FIELD    = 12;
  localparam int unsigned RC5_CONTROL  = 11;
  localparam int unsigned RC5_ADDR_MSB = 10;
  localparam int unsigned RC5_ADDR_LSB = 6;
  localparam int unsigned RC5_CMD_MSB  = 5;

  typedef enum logic [1:0] {
    RC5_IDLE = 2'd0,
    RC5_SEND = 2'd1,
    RC5_GAP  = 2'd2
  } rc5_state_e;

  typedef struct packed {
    logic       field;
    logic       control;
    logic [4:0] address;
    logic [5:0] command;
  } rc5_word_t;

  // Build the on-air frame from a command word.
  function automatic logic [RC5_FRAME_BITS-1:0] rc5_pack(input rc5_word_t w);
    logic [RC5_FRAME_BITS-1:0] f;
    f                            = '0;
    f[RC5_START]                 = 1'b1;
    f[RC5_FIELD]                 = w.field;
    f[RC5_CONTROL]               = w.control;
    f[RC5_ADDR_MSB:RC5_ADDR_LSB] = w.address;
    f[RC5_CMD_MSB:0]             = w.command;
    return f;
  endfunction

endpackage

// File: rtl/rc5_carrier.sv
// Restartable divide-by-DIV square-wave carrier with built-in gating.
// Ports: i_clk/i_rst (sync, active-high); i_restart forces phase 0 and
// output 1; i_enable lets the wave toggle every DIV cycles; o_wave is the
// registered gated carrier (0 whenever not enabled).
module rc5_carrier #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_wave
);

  localparam int unsigned PH_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            wave_q,  wave_d;

  // Next phase / wave level.
  always_comb begin
    phase_d = '0;
    wave_d  = 1'b0;
    if (i_restart) begin
      phase_d = '0;
      wave_d  = 1'b1;
    end else if (i_enable) begin
      if (phase_q == PH_W'(DIV - 1)) begin
        phase_d = '0;
        wave_d  = ~wave_q;
      end else begin
        phase_d = phase_q + PH_W'(1);
        wave_d  = wave_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= '0;
      wave_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wave_q  <= wave_d;
    end
  end

  assign o_wave = wave_q;

endmodule

// File: rtl/rc5_tx.sv
// RC5 infrared transmitter: accepts a command word on a valid/ready
// handshake, sends it as a Manchester-coded 14-bit frame, then holds off
// for GAP_BITS bit periods.
// Ports: i_clk/i_rst (sync, active-high); i_valid/o_ready handshake;
// i_field/i_control/i_address/i_command payload; o_ir IR line (mark=1);
// o_nrz current frame bit; o_busy in SEND/GAP; o_done last frame cycle.
module rc5_tx
  import rc5_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = 32,
  parameter int unsigned GAP_BITS        = 50,
  parameter int unsigned CARRIER_DIV     = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_field,
  input  logic       i_control,
  input  logic [4:0] i_address,
  input  logic [5:0] i_command,
  output logic       o_ir,
  output logic       o_nrz,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CYC_W  = $clog2(HALF_BIT_CYCLES);
  localparam int unsigned HALF_W = 5;
  localparam int unsigned GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned MSB    = RC5_FRAME_BITS - 1;

  rc5_state_e                state_q, state_d;
  logic [RC5_FRAME_BITS-1:0] sh_q,    sh_d;
  logic [HALF_W-1:0]         half_q,  half_d;
  logic [CYC_W-1:0]          cyc_q,   cyc_d;
  logic [GAP_W-1:0]          gap_q,   gap_d;
  logic ready_q, busy_q, nrz_q, done_q;
  logic mark_d, nrz_d, done_d, cyc_last;
  rc5_word_t word;

  assign word     = {i_field, i_control, i_address, i_command};
  assign cyc_last = (cyc_q == CYC_W'(HALF_BIT_CYCLES - 1));

  // Next-state logic; half_q[0] doubles as the half-period flag in GAP.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    half_d  = half_q;
    cyc_d   = cyc_q;
    gap_d   = gap_q;
    case (state_q)
      RC5_IDLE: begin
        if (i_valid && ready_q) begin
          state_d = RC5_SEND;
          sh_d    = rc5_pack(word);
          half_d  = '0;
          cyc_d   = '0;
        end
      end
      RC5_SEND: begin
        cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
        if (cyc_last) begin
          if (half_q == HALF_W'(RC5_HALF_BITS - 1)) begin
            half_d  = '0;
            gap_d   = '0;
            state_d = (GAP_BITS == 0) ? RC5_IDLE : RC5_GAP;
          end else begin
            half_d = half_q + HALF_W'(1);
            // Advance to the next frame bit after its second half.
            if (half_q[0]) sh_d = {sh_q[MSB-1:0], 1'b0};
          end
        end
      end
      RC5_GAP: begin
        cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
        if (cyc_last) begin
          half_d = {half_q[HALF_W-1:1], ~half_q[0]};
          if (half_q[0]) begin
            if (gap_q == GAP_W'(GAP_BITS - 1)) begin
              state_d = RC5_IDLE;
              half_d  = '0;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
      end
      default: state_d = RC5_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    nrz_d  = (state_d == RC5_SEND) && sh_d[MSB];
    mark_d = (state_d == RC5_SEND) && (half_d[0] ? sh_d[MSB] : ~sh_d[MSB]);
    done_d = (state_d == RC5_SEND) &&
             (half_d == HALF_W'(RC5_HALF_BITS - 1)) &&
             (cyc_d == CYC_W'(HALF_BIT_CYCLES - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RC5_IDLE;
      sh_q    <= '0;
      half_q  <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      nrz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      half_q  <= half_d;
      cyc_q   <= cyc_d;
      gap_q   <= gap_d;
      ready_q <= (state_d == RC5_IDLE);
      busy_q  <= (state_d != RC5_IDLE);
      nrz_q   <= nrz_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_nrz   = nrz_q;
  assign o_done  = done_q;

  // IR line: plain Manchester level, or level gated by a restarted carrier.
  if (CARRIER_DIV == 0) begin : g_no_carrier
    logic ir_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) ir_q <= 1'b0;
      else       ir_q <= mark_d;
    end
    assign o_ir = ir_q;
  end else begin : g_carrier
    rc5_carrier #(.DIV(CARRIER_DIV)) u_carrier (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_restart(mark_d && (cyc_d == '0)),
      .i_enable (mark_d),
      .o_wave   (o_ir)
    );
  end

endmodule

// File: tb/tb_rc5_tx.sv
module tb_rc5_tx;

  logic       clk = 1'b0;
  logic       rst, valid;
  logic       field, control;
  logic [4:0] address;
  logic [5:0] command;
  int         sel;
  int         checks = 0;
  int         errors = 0;
  int         cur_n  = 0;

  logic va, vb, vc;
  logic rdy_a, ir_a, nrz_a, busy_a, done_a;
  logic rdy_b, ir_b, nrz_b, busy_b, done_b;
  logic rdy_c, ir_c, nrz_c, busy_c, done_c;
  logic o_rdy, o_ir, o_nrz, o_busy, o_done;

  always #5 clk = ~clk;

  assign va = valid && (sel == 0);
  assign vb = valid && (sel == 1);
  assign vc = valid && (sel == 2);

  rc5_tx #(.HALF_BIT_CYCLES(4), .GAP_BITS(2), .CARRIER_DIV(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(va), .o_ready(rdy_a),
    .i_field(field), .i_control(control), .i_address(address), .i_command(command),
    .o_ir(ir_a), .o_nrz(nrz_a), .o_busy(busy_a), .o_done(done_a));

  rc5_tx #(.HALF_BIT_CYCLES(4), .GAP_BITS(0), .CARRIER_DIV(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(vb), .o_ready(rdy_b),
    .i_field(field), .i_control(control), .i_address(address), .i_command(command),
    .o_ir(ir_b), .o_nrz(nrz_b), .o_busy(busy_b), .o_done(done_b));

  rc5_tx #(.HALF_BIT_CYCLES(8), .GAP_BITS(1), .CARRIER_DIV(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(vc), .o_ready(rdy_c),
    .i_field(field), .i_control(control), .i_address(address), .i_command(command),
    .o_ir(ir_c), .o_nrz(nrz_c), .o_busy(busy_c), .o_done(done_c));

  always_comb begin
    case (sel)
      1:       {o_rdy, o_ir, o_nrz, o_busy, o_done} = {rdy_b, ir_b, nrz_b, busy_b, done_b};
      2:       {o_rdy, o_ir, o_nrz, o_busy, o_done} = {rdy_c, ir_c, nrz_c, busy_c, done_c};
      default: {o_rdy, o_ir, o_nrz, o_busy, o_done} = {rdy_a, ir_a, nrz_a, busy_a, done_a};
    endcase
  end

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s sel=%0d n=%0d observed=%0h expected=%0h", tag, sel, cur_n, obs, exp);
    end
  endtask

  task automatic rand_payload();
    field   = 1'($urandom_range(0, 1));
    control = 1'($urandom_range(0, 1));
    address = 5'($urandom_range(0, 31));
    command = 6'($urandom_range(0, 63));
  endtask

  // Send the payload currently on the inputs and check every cycle of the
  // frame, gap and first idle cycle against a model built from the RC5 rules.
  task automatic do_frame(input int h, input int g, input int div,
                          input bit keep_valid, input bit mutate, input int abort_n);
    logic [13:0] ef, dec;
    int          total, hb, j;
    logic        b, lvl, e_ir;
    chk("ready_before", o_rdy, 1'b1);
    valid = 1'b1;
    @(posedge clk);
    ef    = {1'b1, field, control, address, command};
    dec   = '0;
    total = 28 * h + 2 * g * h + 1;
    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      cur_n = n;
      if (n == 1 && !keep_valid) valid = 1'b0;
      if (n <= 28 * h) begin
        hb   = (n - 1) / h;
        j    = (n - 1) % h;
        b    = ef[13 - hb / 2];
        lvl  = (hb % 2 == 1) ? b : ~b;
        e_ir = lvl && (div == 0 || ((j / div) % 2) == 0);
        chk("ir", o_ir, e_ir);
        chk("nrz", o_nrz, b);
        chk("done", o_done, n == 28 * h);
        chk("busy", o_busy, 1'b1);
        chk("ready_frame", o_rdy, 1'b0);
        // Receiver-style decode: second half of each bit carries its value.
        if ((n - 1) % (2 * h) == (3 * h) / 2) dec = {dec[12:0], o_ir};
        if (n == 28 * h && div == 0) chk("loopback", dec, ef);
      end else if (n < total) begin
        chk("ir_gap", o_ir, 1'b0);
        chk("nrz_gap", o_nrz, 1'b0);
        chk("done_gap", o_done, 1'b0);
        chk("busy_gap", o_busy, 1'b1);
        chk("ready_gap", o_rdy, 1'b0);
      end else begin
        chk("ir_idle", o_ir, 1'b0);
        chk("nrz_idle", o_nrz, 1'b0);
        chk("busy_idle", o_busy, 1'b0);
        chk("ready_idle", o_rdy, 1'b1);
      end
      if (mutate && n == 2 * h + 1) rand_payload();
      if (n == abort_n) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ir", o_ir, 1'b0);
        chk("rst_nrz", o_nrz, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_ready", o_rdy, 1'b1);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [11:0] p0, p1;
    rst   = 1'b1;
    valid = 1'b0;
    sel   = 0;
    field = 1'b0; control = 1'b0; address = '0; command = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_a", rdy_a, 1'b1);
    chk("reset_ir_a", ir_a, 1'b0);
    chk("reset_nrz_a", nrz_a, 1'b0);
    chk("reset_busy_a", busy_a, 1'b0);
    chk("reset_done_a", done_a, 1'b0);
    chk("reset_ready_b", rdy_b, 1'b1);
    chk("reset_ir_c", ir_c, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frame: field=1, control=0, addr=05, cmd=0C.
    field = 1'b1; control = 1'b0; address = 5'h05; command = 6'h0C;
    do_frame(4, 2, 0, 1'b0, 1'b0, 0);

    // Valid held high, alternating payloads, inputs disturbed mid-frame.
    p0 = 12'($urandom);
    p1 = ~p0;
    for (int i = 0; i < 4; i++) begin
      {field, control, address, command} = (i % 2 == 0) ? p0 : p1;
      do_frame(4, 2, 0, i < 3, 1'b1, 0);
    end

    // Reset mid-frame (half-bit 9), then mid-gap (3rd gap cycle).
    rand_payload();
    do_frame(4, 2, 0, 1'b0, 1'b0, 9 * 4 + 1);
    rand_payload();
    do_frame(4, 2, 0, 1'b0, 1'b0, 0);
    rand_payload();
    do_frame(4, 2, 0, 1'b0, 1'b0, 28 * 4 + 3);
    rand_payload();
    do_frame(4, 2, 0, 1'b0, 1'b0, 0);

    // Carrier instance.
    sel = 2;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      do_frame(8, 1, 1, i < 2, 1'b0, 0);
    end

    // Back-to-back frames with no gap, 500 random payloads decoded.
    sel = 1;
    for (int i = 0; i < 500; i++) begin
      rand_payload();
      do_frame(4, 0, 0, i < 499, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
